ch_scan_serializer: RTL and testbench
=====================================

CH_SCAN_SERIALIZER -- requirements
Module: ch_scan_serializer

Interface
REQ-001 Parameter BIT_DIV, default 8: clk cycles per serial bit; even, 4..64.
REQ-002 Parameter CH_NUM, default 32: channels per frame.
REQ-003 Parameter CH_W, default 16: bits per channel word.
REQ-004 clk  in  1  system clock, 25 MHz.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 tick  in  1  one-clk frame start strobe, 5 kHz, from the pulse stage.
REQ-007 wr_en  in  1  channel table write enable.
REQ-008 wr_addr  in  5  channel index 0..CH_NUM-1.
REQ-009 wr_data  in  CH_W  channel value.
REQ-010 ovr_clr  in  1  clears overrun.
REQ-011 sclk  out  1  serial bit clock.
REQ-012 sdata  out  1  serial data, MSB first.
REQ-013 frame  out  1  high while any frame bit is on the line.
REQ-014 busy  out  1  high from tick acceptance to end of last bit.
REQ-015 overrun  out  1  sticky flag, tick arrived while busy.

Function
REQ-016 Channel table: CH_NUM x CH_W registers; write when wr_en, any state; wr_addr >= CH_NUM ignored.
REQ-017 FSM states: IDLE, LOAD, SHIFT, NEXT.
REQ-018 IDLE: tick=1 -> LOAD; busy=1 from next cycle.
REQ-019 LOAD: one cycle; latch table[ch_idx] into shift register; -> SHIFT.
REQ-020 Same-cycle write to the word being latched: old value is latched (read-before-write).
REQ-021 SHIFT: each bit held BIT_DIV cycles; sclk low first BIT_DIV/2 cycles, high second half; sdata changes only at bit start.
REQ-022 After last bit of word: -> NEXT; NEXT increments ch_idx; ch_idx < CH_NUM -> LOAD, else ch_idx=0, -> IDLE.
REQ-023 Latency: tick at cycle T -> LOAD at T+1 -> first bit and frame=1 at T+2.
REQ-024 sdata and sclk held low, frame low, in IDLE, LOAD and NEXT; frame is high only during SHIFT (gaps of 2 cycles between words).
REQ-025 tick while busy: ignored; overrun set next cycle.
REQ-026 overrun cleared by ovr_clr; simultaneous set and clear -> set wins.
REQ-027 Frame duration at defaults: 32 x (16 x 8 + 2) = 4160 clks = 166.4 us < 200 us tick period.

Reset
REQ-028 rst_n low: state IDLE, ch_idx 0, bit counters 0, sclk 0, sdata 0, frame 0, busy 0, overrun 0, immediately (asynchronous).
REQ-029 Channel table resets to all zeros.
REQ-030 Reset mid-frame aborts the frame; the first tick after release starts a full frame from channel 0.

Configuration
REQ-031 Macro CH_PARITY_EN defined: one odd-parity bit appended after each word LSB, word length CH_W+1; frame at defaults 4416 clks.
REQ-032 CH_PARITY_EN undefined: word length CH_W; no parity logic present.

Structure
REQ-033 Package buks_pkg holds CH_NUM_DEF, CH_W_DEF, BIT_DIV_DEF and the FSM state enum.
REQ-034 Sub-module bit_timer: BIT_DIV counter emitting sclk phase, bit_start and bit_end strobes; cleared outside SHIFT.

Verification
REQ-035 Write ch0=0xA5C3, ch31=0x0001, others 0; tick -> frame high at T+2, first 16 bits 1010010111000011, last word ends in single 1, busy low at T+4160.
REQ-036 Tick at frame cycle 1000 -> overrun=1, frame unaffected, ends at T+4160; ovr_clr -> overrun=0.
REQ-037 Write ch5=0x1234 in its LOAD cycle (ch5 previously 0x0000) -> 0x0000 transmitted; next frame transmits 0x1234.
REQ-038 rst_n low at cycle 2000 -> all outputs 0 asynchronously; tick after release -> channel 0 sent first.
REQ-039 CH_PARITY_EN defined, ch0=0x0003 -> 17 bits, parity bit 1; ch0=0x0007 -> parity bit 0; frame length 4416.
REQ-040 BIT_DIV=4, any data -> sclk period 4 clks, 2 low/2 high, frame length 32 x 66 = 2112.

Source files
------------

// File: rtl/buks_pkg.sv
// Shared defaults and FSM state encoding for the channel scan serializer.
package buks_pkg;

   localparam int unsigned CH_NUM_DEF  = 32;
   localparam int unsigned CH_W_DEF    = 16;
   localparam int unsigned BIT_DIV_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_NEXT  = 2'd3
   } state_e;

endpackage

// File: rtl/ch_scan_serializer_bit_timer.sv
// Serial bit timer: per-bit cycle counter with registered sclk phase and bit start/end strobes.
// All outputs line up with the cycle in which the enabling state is actually active.
module bit_timer
   import buks_pkg::*;
#(
   parameter int unsigned BIT_DIV = BIT_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic sclk_o,
   output logic bit_start_o,
   output logic bit_end_o
);

   localparam int unsigned      CNT_W = $clog2(BIT_DIV);
   localparam logic [CNT_W-1:0] HALF  = CNT_W'(BIT_DIV / 2);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIT_DIV - 1);

   logic             run_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, start_q, end_q;

   // en_i is the enable for the coming cycle; a fresh run always starts at count 0
   always_comb begin
      cnt_d = '0;
      if (en_i && run_q) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         sclk_q  <= 1'b0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         run_q   <= en_i;
         cnt_q   <= cnt_d;
         sclk_q  <= en_i && (cnt_d >= HALF);
         start_q <= en_i && (cnt_d == '0);
         end_q   <= en_i && (cnt_d == LAST);
      end
   end

   assign sclk_o      = sclk_q;
   assign bit_start_o = start_q;
   assign bit_end_o   = end_q;

endmodule

// File: rtl/ch_scan_serializer.sv
// Frame serializer: on tick, shifts every channel table word out MSB first with sclk/frame framing.
// Optional feature macro CH_PARITY_EN appends an odd-parity bit after each word.
module ch_scan_serializer
   import buks_pkg::*;
#(
   parameter int unsigned BIT_DIV = BIT_DIV_DEF,
   parameter int unsigned CH_NUM  = CH_NUM_DEF,
   parameter int unsigned CH_W    = CH_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tick,
   input  logic            wr_en,
   input  logic [4:0]      wr_addr,
   input  logic [CH_W-1:0] wr_data,
   input  logic            ovr_clr,
   output logic            sclk,
   output logic            sdata,
   output logic            frame,
   output logic            busy,
   output logic            overrun
);

`ifdef CH_PARITY_EN
   localparam int unsigned WORD_W = CH_W + 1;
`else
   localparam int unsigned WORD_W = CH_W;
`endif
   localparam int unsigned       IDX_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int unsigned       BIT_CW   = $clog2(WORD_W + 1);
   localparam logic [IDX_W-1:0]  LAST_CH  = IDX_W'(CH_NUM - 1);
   localparam logic [BIT_CW-1:0] LAST_BIT = BIT_CW'(WORD_W);

   state_e              state_q, state_d;
   logic [CH_W-1:0]     tbl_q [CH_NUM];
   logic [IDX_W-1:0]    ch_idx_q, ch_idx_d;
   logic [BIT_CW-1:0]   bit_idx_q, bit_idx_d;
   logic [WORD_W-1:0]   sh_q, sh_d;
   logic                sdata_q, sdata_d;
   logic                frame_q, frame_d;
   logic                busy_q, busy_d;
   logic                ovr_q, ovr_d;
   logic [CH_W-1:0]     rd_word_c;
   logic [WORD_W-1:0]   load_word_c;
   logic                tmr_sclk, tmr_start, tmr_end;

   // Channel table; a write in the LOAD cycle lands after the read, so the old word is sent
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH_NUM; i++) tbl_q[i] <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (32'(wr_addr) == i) tbl_q[i] <= wr_data;
         end
      end
   end

   assign rd_word_c = tbl_q[ch_idx_q];
`ifdef CH_PARITY_EN
   assign load_word_c = {rd_word_c, ~^rd_word_c};
`else
   assign load_word_c = rd_word_c;
`endif

   bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (state_d == ST_SHIFT),
      .sclk_o      (tmr_sclk),
      .bit_start_o (tmr_start),
      .bit_end_o   (tmr_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (tick) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SHIFT;
         ST_SHIFT: if (tmr_end && (bit_idx_q == LAST_BIT)) state_d = ST_NEXT;
         ST_NEXT:  state_d = (ch_idx_q == LAST_CH) ? ST_IDLE : ST_LOAD;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered-output next values; bit_idx counts bits already started
   always_comb begin
      ch_idx_d  = ch_idx_q;
      bit_idx_d = bit_idx_q;
      sh_d      = sh_q;
      case (state_q)
         ST_LOAD: begin
            sh_d      = load_word_c;
            bit_idx_d = '0;
         end
         ST_SHIFT: begin
            if (tmr_start) bit_idx_d = bit_idx_q + BIT_CW'(1);
            if (tmr_end)   sh_d      = sh_q << 1;
         end
         ST_NEXT: ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + IDX_W'(1);
         default: ;
      endcase
      sdata_d = (state_d == ST_SHIFT) && sh_d[WORD_W-1];
      frame_d = (state_d == ST_SHIFT);
      busy_d  = (state_d == ST_LOAD) || (state_d == ST_SHIFT) ||
                ((state_d == ST_NEXT) && (ch_idx_q != LAST_CH));
      ovr_d   = (tick && busy_q) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_idx_q  <= '0;
         bit_idx_q <= '0;
         sh_q      <= '0;
         sdata_q   <= 1'b0;
         frame_q   <= 1'b0;
         busy_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         ch_idx_q  <= ch_idx_d;
         bit_idx_q <= bit_idx_d;
         sh_q      <= sh_d;
         sdata_q   <= sdata_d;
         frame_q   <= frame_d;
         busy_q    <= busy_d;
         ovr_q     <= ovr_d;
      end
   end

   assign sclk    = tmr_sclk;
   assign sdata   = sdata_q;
   assign frame   = frame_q;
   assign busy    = busy_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_ch_scan_serializer.sv
// Directed bench for ch_scan_serializer: table of channel words plus overrun, LOAD-cycle write and reset sequences.
module tb_ch_scan_serializer;

   localparam int BIT_DIV = 8;
   localparam int CH_NUM  = 32;
   localparam int CH_W    = 16;
`ifdef CH_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   localparam int WORD_W = CH_W + PAR_EN;
   localparam int WC     = WORD_W * BIT_DIV + 2;
   localparam int FRAME  = CH_NUM * WC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        ovr_clr = 1'b0;
   logic        sclk, sdata, frame, busy, overrun;

   always #20 clk = ~clk;

   ch_scan_serializer #(.BIT_DIV(BIT_DIV), .CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .ovr_clr (ovr_clr),
      .sclk    (sclk),
      .sdata   (sdata),
      .frame   (frame),
      .busy    (busy),
      .overrun (overrun)
   );

   typedef struct packed {logic busy; logic frame; logic sclk; logic sdata; logic ovr;} obs_t;
   typedef struct {int ch; logic [15:0] data; logic par;} vec_t;

   obs_t              obs [FRAME+1];
   obs_t              rst_obs;
   logic [WORD_W-1:0] cap  [CH_NUM];
   logic [WORD_W-1:0] expw [CH_NUM];
   logic [CH_W-1:0]   tbl_m [CH_NUM];
   vec_t              vecs [6];
   int                first_bad;
   int                total = 0;
   int                bad = 0;
   int                errs;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] mk_word(input logic [CH_W-1:0] d, input logic p);
      if (PAR_EN != 0) return WORD_W'({d, p});
      return WORD_W'(d);
   endfunction

   task automatic wr(input int ch, input logic [15:0] d);
      wr_en = 1'b1; wr_addr = 5'(ch); wr_data = d;
      step();
      wr_en = 1'b0;
      tbl_m[ch] = d;
   endtask

   // Tick, then walk the frame cycle by cycle against the position model; f counts cycles after the tick
   task automatic run_frame(input int tick_at, input int clr_at, input int wr_at, input int wa,
                            input logic [15:0] wd, input int rst_at, output int n_err);
      int k, r, c, b;
      logic ef, es, ed, eb;
      logic [WORD_W-1:0] w;
      n_err = 0;
      first_bad = -1;
      for (int i = 0; i < CH_NUM; i++) begin
         expw[i] = mk_word(tbl_m[i], ~^tbl_m[i]);
         cap[i]  = '0;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      for (int f = 1; f <= FRAME; f++) begin
         obs[f] = {busy, frame, sclk, sdata, overrun};
         ef = 1'b0; es = 1'b0; ed = 1'b0; eb = (f < FRAME);
         if (f >= 2) begin
            k = (f - 2) / WC;
            r = (f - 2) % WC;
            if (r < WORD_W * BIT_DIV) begin
               b  = WORD_W - 1 - r / BIT_DIV;
               c  = r % BIT_DIV;
               w  = expw[k];
               ef = 1'b1;
               es = (c >= BIT_DIV / 2);
               ed = w[b];
               if (c == 0) cap[k][b] = sdata;
            end
         end
         if ({busy, frame, sclk, sdata} !== {eb, ef, es, ed}) begin
            n_err++;
            if (first_bad < 0) first_bad = f;
         end
         tick    = (f == tick_at);
         ovr_clr = (f == clr_at);
         if (f == wr_at) begin
            wr_en = 1'b1; wr_addr = 5'(wa); wr_data = wd;
         end else begin
            wr_en = 1'b0;
         end
         if (f == rst_at) begin
            rst_n = 1'b0;
            #1;
            rst_obs = {busy, frame, sclk, sdata, overrun};
            tick = 1'b0; ovr_clr = 1'b0; wr_en = 1'b0;
            return;
         end
         step();
      end
      tick = 1'b0; ovr_clr = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{ch: 0,  data: 16'hA5C3, par: 1'b1};
      vecs[1] = '{ch: 31, data: 16'h0001, par: 1'b0};
      vecs[2] = '{ch: 3,  data: 16'h0003, par: 1'b1};
      vecs[3] = '{ch: 7,  data: 16'h0007, par: 1'b0};
      vecs[4] = '{ch: 10, data: 16'hFFFF, par: 1'b1};
      vecs[5] = '{ch: 20, data: 16'h8000, par: 1'b0};
      for (int i = 0; i < CH_NUM; i++) tbl_m[i] = '0;

      rst_n = 1'b0;
      step(); step();
      chk("reset_outputs", 32'({busy, frame, sclk, sdata, overrun}), 32'd0);
      rst_n = 1'b1;
      step();

      // Frame 1: table vectors
      for (int i = 0; i < 6; i++) wr(vecs[i].ch, vecs[i].data);
      run_frame(-1, -1, -1, 0, 16'h0, -1, errs);
      chk($sformatf("frame1_walk_first_bad_cycle_%0d", first_bad), 32'(errs), 32'd0);
      for (int i = 0; i < 6; i++)
         chk($sformatf("frame1_word_ch%0d", vecs[i].ch), 32'(cap[vecs[i].ch]),
             32'(mk_word(vecs[i].data, vecs[i].par)));
      chk("frame_low_in_load", 32'(obs[1].frame), 32'd0);
      chk("frame_high_at_t2", 32'(obs[2].frame), 32'd1);
      chk("busy_in_last_bit", 32'(obs[FRAME-1].busy), 32'd1);
      chk("busy_low_at_end", 32'(obs[FRAME].busy), 32'd0);
      chk("no_overrun_idle_tick", 32'(obs[FRAME].ovr), 32'd0);

      // Frame 2: tick plus simultaneous clear at cycle 1000, set must win
      run_frame(1000, 1000, -1, 0, 16'h0, -1, errs);
      chk($sformatf("frame2_walk_first_bad_cycle_%0d", first_bad), 32'(errs), 32'd0);
      chk("ovr_before_tick", 32'(obs[1000].ovr), 32'd0);
      chk("ovr_set_wins", 32'(obs[1001].ovr), 32'd1);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'd0);

      // Frame 3: write ch5 in its LOAD cycle, old word goes out
      run_frame(-1, -1, 1 + 5 * WC, 5, 16'h1234, -1, errs);
      chk($sformatf("frame3_walk_first_bad_cycle_%0d", first_bad), 32'(errs), 32'd0);
      chk("load_write_old_word", 32'(cap[5]), 32'(mk_word(16'h0000, 1'b1)));
      tbl_m[5] = 16'h1234;
      run_frame(-1, -1, -1, 0, 16'h0, -1, errs);
      chk($sformatf("frame4_walk_first_bad_cycle_%0d", first_bad), 32'(errs), 32'd0);
      chk("load_write_new_word", 32'(cap[5]), 32'(mk_word(16'h1234, 1'b0)));

      // Frame 5: overrun set, then reset mid-frame
      run_frame(1000, -1, -1, 0, 16'h0, 2000, errs);
      chk($sformatf("frame5_walk_first_bad_cycle_%0d", first_bad), 32'(errs), 32'd0);
      chk("ovr_before_reset", 32'(obs[1999].ovr), 32'd1);
      chk("async_reset_outputs", 32'(rst_obs), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < CH_NUM; i++) tbl_m[i] = '0;
      wr(0, 16'h00F1);
      run_frame(-1, -1, -1, 0, 16'h0, -1, errs);
      chk($sformatf("frame6_walk_first_bad_cycle_%0d", first_bad), 32'(errs), 32'd0);
      chk("post_reset_ch0_first", 32'(cap[0]), 32'(mk_word(16'h00F1, 1'b0)));
      chk("post_reset_table_cleared", 32'(cap[31]), 32'(mk_word(16'h0000, 1'b1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
